// File: rtl/condlogic_pkg.sv
// Shared types and constants for the conditional-execution pipeline slice.
// Holds the condition-code encoding, flag bit positions and the E-stage control word.
package condlogic_pkg;

   typedef enum logic [3:0] {
      EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
      MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
      HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
      GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
   } cond_t;

   localparam int N_IDX = 3;
   localparam int Z_IDX = 2;
   localparam int C_IDX = 1;
   localparam int V_IDX = 0;

   // Flag-write groups are pre-expanded to a per-flag mask when captured into E.
   typedef struct packed {
      cond_t      cond;
      logic [3:0] flag_mask;
      logic       pcs;
      logic       regw;
      logic       memw;
      logic       nowrite;
      logic       valid;
   } ectrl_t;

endpackage

// File: rtl/condlogic_if.sv
// Decode/execute control bus for condlogic_pipe.
// The slave modport is the pipeline's view; the master modport is the driver's view.
interface condlogic_if #(
   parameter int NUM_FLAG_GROUPS = 2,
   parameter int STAT_W          = 16
);
   logic [3:0]                 CondD;
   logic [NUM_FLAG_GROUPS-1:0] FlagWD;
   logic                       PCSD;
   logic                       RegWD;
   logic                       MemWD;
   logic                       NoWriteD;
   logic                       ValidD;
   logic                       StallE;
   logic                       FlushE;
   logic [3:0]                 ALUFlagsE;
   logic                       PCSrcE;
   logic                       RegWriteE;
   logic                       MemWriteE;
   logic                       CondExE;
   logic [3:0]                 FlagsE;
   logic [STAT_W-1:0]          ExecCnt;
   logic [STAT_W-1:0]          SquashCnt;

   modport master (
      output CondD, FlagWD, PCSD, RegWD, MemWD, NoWriteD, ValidD,
      output StallE, FlushE, ALUFlagsE,
      input  PCSrcE, RegWriteE, MemWriteE, CondExE, FlagsE, ExecCnt, SquashCnt
   );

   modport slave (
      input  CondD, FlagWD, PCSD, RegWD, MemWD, NoWriteD, ValidD,
      input  StallE, FlushE, ALUFlagsE,
      output PCSrcE, RegWriteE, MemWriteE, CondExE, FlagsE, ExecCnt, SquashCnt
   );
endinterface

// File: rtl/condlogic_cond_eval.sv
// Combinational condition-code evaluator: maps a 4-bit condition and {N,Z,C,V} to pass/fail.
module cond_eval
   import condlogic_pkg::*;
(
   input  cond_t      cond_i,
   input  logic [3:0] flags_i,
   output logic       condex_o
);
   logic n, z, c, v;

   assign n = flags_i[N_IDX];
   assign z = flags_i[Z_IDX];
   assign c = flags_i[C_IDX];
   assign v = flags_i[V_IDX];

   always_comb begin
      condex_o = 1'b0;
      case (cond_i)
         EQ: condex_o = z;
         NE: condex_o = ~z;
         CS: condex_o = c;
         CC: condex_o = ~c;
         MI: condex_o = n;
         PL: condex_o = ~n;
         VS: condex_o = v;
         VC: condex_o = ~v;
         HI: condex_o = c & ~z;
         LS: condex_o = ~(c & ~z);
         GE: condex_o = (n == v);
         LT: condex_o = (n != v);
         GT: condex_o = ~z & (n == v);
         LE: condex_o = ~(~z & (n == v));
         AL: condex_o = 1'b1;
         NV: condex_o = 1'b0;
      endcase
   end
endmodule

// File: rtl/condlogic_pipe.sv
// Execute-stage conditional logic: D->E control register, condition qualification,
// committed flag groups and saturating retire statistics.
module condlogic_pipe
   import condlogic_pkg::*;
#(
   parameter int NUM_FLAG_GROUPS = 2,
   parameter int STAT_W          = 16
)(
   input logic       clk,
   input logic       reset,
   condlogic_if.slave bus
);
   localparam int GW = 4 / NUM_FLAG_GROUPS;

   generate
      if ((NUM_FLAG_GROUPS < 1) || (NUM_FLAG_GROUPS > 4) || (4 % NUM_FLAG_GROUPS != 0)) begin : g_bad_groups
         $error("condlogic_pipe: NUM_FLAG_GROUPS must divide 4");
      end
      if ((STAT_W < 2) || (STAT_W > 32)) begin : g_bad_statw
         $error("condlogic_pipe: STAT_W must be in 2..32");
      end
   endgenerate

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val);
      return (&val) ? val : val + 1'b1;
   endfunction

   function automatic logic [3:0] expand_fw(input logic [NUM_FLAG_GROUPS-1:0] fw);
      logic [3:0] mask;
      for (int k = 0; k < 4; k++) mask[k] = fw[k / GW];
      return mask;
   endfunction

   ectrl_t            e_q, e_d;
   logic [3:0]        flags_q, flags_d;
   logic [STAT_W-1:0] exec_q, exec_d;
   logic [STAT_W-1:0] squash_q, squash_d;
   logic              condex;
   logic              qual;
   logic              retire;

   // D -> E capture; flush beats stall so a squashed slot never lingers.
   always_comb begin
      e_d = e_q;
      if (bus.FlushE) begin
         e_d = '0;
      end else if (!bus.StallE) begin
         e_d.cond      = cond_t'(bus.CondD);
         e_d.flag_mask = expand_fw(bus.FlagWD);
         e_d.pcs       = bus.PCSD;
         e_d.regw      = bus.RegWD;
         e_d.memw      = bus.MemWD;
         e_d.nowrite   = bus.NoWriteD;
         e_d.valid     = bus.ValidD;
      end
   end

   cond_eval u_cond_eval (
      .cond_i   (e_q.cond),
      .flags_i  (flags_q),
      .condex_o (condex)
   );

   assign qual   = e_q.valid & condex;
   assign retire = e_q.valid & ~bus.StallE;

   // Flags commit only on the cycle the instruction leaves E, so a stalled
   // instruction keeps evaluating against the flags it entered with.
   always_comb begin
      flags_d = flags_q;
      if (qual && !bus.StallE) begin
         for (int k = 0; k < 4; k++) begin
            if (e_q.flag_mask[k]) flags_d[k] = bus.ALUFlagsE[k];
         end
      end
   end

   always_comb begin
      exec_d   = exec_q;
      squash_d = squash_q;
      if (retire) begin
         if (condex) exec_d   = sat_inc(exec_q);
         else        squash_d = sat_inc(squash_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_q      <= '0;
         flags_q  <= 4'b0000;
         exec_q   <= '0;
         squash_q <= '0;
      end else begin
         e_q      <= e_d;
         flags_q  <= flags_d;
         exec_q   <= exec_d;
         squash_q <= squash_d;
      end
   end

   assign bus.CondExE   = condex;
   assign bus.PCSrcE    = e_q.pcs & qual;
   assign bus.RegWriteE = e_q.regw & qual & ~e_q.nowrite;
   assign bus.MemWriteE = e_q.memw & qual;
   assign bus.FlagsE    = flags_q;
   assign bus.ExecCnt   = exec_q;
   assign bus.SquashCnt = squash_q;
endmodule

// File: tb/tb_condlogic_pipe.sv
// Bench for condlogic_pipe: directed scenarios pinned with literal values, then
// randomized traffic checked each cycle against an architectural model.
module tb_condlogic_pipe;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   condlogic_if #(.NUM_FLAG_GROUPS(2), .STAT_W(16)) bus1 ();
   condlogic_if #(.NUM_FLAG_GROUPS(2), .STAT_W(2))  bus2 ();

   condlogic_pipe #(.NUM_FLAG_GROUPS(2), .STAT_W(16)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
   condlogic_pipe #(.NUM_FLAG_GROUPS(2), .STAT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

   int n_checks = 0;
   int n_pass   = 0;

   // Architectural model state
   logic       m_known = 1'b0;
   logic       m_valid, m_pcs, m_regw, m_memw, m_nowr;
   logic [3:0] m_cond;
   logic [1:0] m_fw;
   logic [3:0] m_flags;
   int         m_exec, m_squash;

   // Current stimulus
   logic [3:0] s_cond, s_alu;
   logic [1:0] s_fw;
   logic       s_pcs, s_regw, s_memw, s_nowr, s_valid, s_stall, s_flush;

   function automatic logic arch_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      if (c == 4'hE) return 1'b1;
      if (c == 4'hF) return 1'b0;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy & ~z;
         3'd5: base = (n == v);
         default: base = ~z & (n == v);
      endcase
      return base ^ c[0];
   endfunction

   function automatic int sat(input int val, input int maxv);
      return (val > maxv) ? maxv : val;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
   endtask

   task automatic drive(input logic [3:0] cond, input logic [1:0] fw, input logic pcs,
                        input logic regw, input logic memw, input logic nowr, input logic valid,
                        input logic stall, input logic flush, input logic [3:0] alu);
      s_cond = cond; s_fw = fw; s_pcs = pcs; s_regw = regw; s_memw = memw;
      s_nowr = nowr; s_valid = valid; s_stall = stall; s_flush = flush; s_alu = alu;
      bus1.CondD = cond; bus1.FlagWD = fw; bus1.PCSD = pcs; bus1.RegWD = regw;
      bus1.MemWD = memw; bus1.NoWriteD = nowr; bus1.ValidD = valid;
      bus1.StallE = stall; bus1.FlushE = flush; bus1.ALUFlagsE = alu;
      bus2.CondD = cond; bus2.FlagWD = fw; bus2.PCSD = pcs; bus2.RegWD = regw;
      bus2.MemWD = memw; bus2.NoWriteD = nowr; bus2.ValidD = valid;
      bus2.StallE = stall; bus2.FlushE = flush; bus2.ALUFlagsE = alu;
   endtask

   task automatic bubble(input logic [3:0] alu);
      drive(4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, alu);
   endtask

   task automatic compare_all();
      logic cx, q;
      if (!m_known) return;
      cx = arch_cond(m_cond, m_flags);
      q  = m_valid & cx;
      chk("CondExE",   {31'd0, bus1.CondExE},   {31'd0, cx});
      chk("PCSrcE",    {31'd0, bus1.PCSrcE},    {31'd0, m_pcs & q});
      chk("RegWriteE", {31'd0, bus1.RegWriteE}, {31'd0, m_regw & q & ~m_nowr});
      chk("MemWriteE", {31'd0, bus1.MemWriteE}, {31'd0, m_memw & q});
      chk("FlagsE",    {28'd0, bus1.FlagsE},    {28'd0, m_flags});
      chk("ExecCnt",   {16'd0, bus1.ExecCnt},   sat(m_exec, 65535));
      chk("SquashCnt", {16'd0, bus1.SquashCnt}, sat(m_squash, 65535));
      chk("ExecCnt_w2",   {30'd0, bus2.ExecCnt},   sat(m_exec, 3));
      chk("SquashCnt_w2", {30'd0, bus2.SquashCnt}, sat(m_squash, 3));
      chk("FlagsE_w2",    {28'd0, bus2.FlagsE},    {28'd0, m_flags});
   endtask

   task automatic model_edge();
      logic cx;
      if (reset) begin
         m_known = 1'b1;
         m_valid = 0; m_pcs = 0; m_regw = 0; m_memw = 0; m_nowr = 0;
         m_cond = 4'h0; m_fw = 2'b00; m_flags = 4'h0; m_exec = 0; m_squash = 0;
         return;
      end
      if (!m_known) return;
      cx = arch_cond(m_cond, m_flags);
      if (m_valid && !s_stall) begin
         if (cx) begin
            m_exec++;
            if (m_fw[0]) m_flags[1:0] = s_alu[1:0];
            if (m_fw[1]) m_flags[3:2] = s_alu[3:2];
         end else begin
            m_squash++;
         end
      end
      if (s_flush) begin
         m_valid = 0; m_pcs = 0; m_regw = 0; m_memw = 0; m_nowr = 0;
         m_cond = 4'h0; m_fw = 2'b00;
      end else if (!s_stall) begin
         m_valid = s_valid; m_pcs = s_pcs; m_regw = s_regw; m_memw = s_memw;
         m_nowr = s_nowr; m_cond = s_cond; m_fw = s_fw;
      end
   endtask

   task automatic tick();
      #2;
      compare_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bubble(4'h0);
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bubble(4'h0);
      @(negedge clk);
      do_reset();
      chk("rst_FlagsE",  {28'd0, bus1.FlagsE}, 32'h0);
      chk("rst_ExecCnt", {16'd0, bus1.ExecCnt}, 32'h0);
      chk("rst_PCSrcE",  {31'd0, bus1.PCSrcE}, 32'h0);
      chk("rst_CondExE", {31'd0, bus1.CondExE}, 32'h0);

      // CMP sets Z, then BEQ takes
      drive(4'hE, 2'b11, 0, 0, 0, 0, 1, 0, 0, 4'h0); tick();
      drive(4'h0, 2'b00, 1, 0, 0, 0, 1, 0, 0, 4'b0100); tick();
      chk("cmp_FlagsE", {28'd0, bus1.FlagsE}, 32'h4);
      chk("beq_PCSrcE", {31'd0, bus1.PCSrcE}, 32'h1);
      bubble(4'h0); tick();
      chk("beq_ExecCnt", {16'd0, bus1.ExecCnt}, 32'd2);

      // Failing EQ squashes a register write; NoWrite suppresses an AL write
      do_reset();
      drive(4'h0, 2'b00, 0, 1, 0, 0, 1, 0, 0, 4'h0); tick();
      chk("eq_fail_RegWriteE", {31'd0, bus1.RegWriteE}, 32'h0);
      drive(4'hE, 2'b00, 0, 1, 0, 1, 1, 0, 0, 4'h0); tick();
      chk("eq_fail_SquashCnt", {16'd0, bus1.SquashCnt}, 32'd1);
      chk("nowrite_RegWriteE", {31'd0, bus1.RegWriteE}, 32'h0);
      bubble(4'h0); tick();
      chk("nowrite_ExecCnt", {16'd0, bus1.ExecCnt}, 32'd1);

      // Stalled flag-setter commits only once the stall lifts
      do_reset();
      drive(4'hE, 2'b11, 0, 0, 0, 0, 1, 0, 0, 4'h0); tick();
      for (int i = 0; i < 3; i++) begin
         bubble(4'b1000); s_stall = 1; bus1.StallE = 1; bus2.StallE = 1;
         tick();
         chk("stall_FlagsE", {28'd0, bus1.FlagsE}, 32'h0);
         chk("stall_ExecCnt", {16'd0, bus1.ExecCnt}, 32'd0);
      end
      bubble(4'b1000); tick();
      chk("unstall_FlagsE", {28'd0, bus1.FlagsE}, 32'h8);
      chk("unstall_ExecCnt", {16'd0, bus1.ExecCnt}, 32'd1);

      // Flush with stall: no retire, bubble enters E; NV never executes
      do_reset();
      drive(4'hE, 2'b00, 1, 0, 0, 0, 1, 0, 0, 4'h0); tick();
      drive(4'hE, 2'b00, 1, 0, 0, 0, 1, 1, 1, 4'h0); tick();
      chk("flush_PCSrcE", {31'd0, bus1.PCSrcE}, 32'h0);
      chk("flush_ExecCnt", {16'd0, bus1.ExecCnt}, 32'd0);
      drive(4'hF, 2'b00, 1, 0, 0, 0, 1, 0, 0, 4'h0); tick();
      chk("nv_CondExE", {31'd0, bus1.CondExE}, 32'h0);
      chk("nv_PCSrcE", {31'd0, bus1.PCSrcE}, 32'h0);
      bubble(4'h0); tick();
      chk("nv_SquashCnt", {16'd0, bus1.SquashCnt}, 32'd1);

      // Upper group only, then saturation of the narrow counter
      do_reset();
      drive(4'hE, 2'b10, 0, 0, 0, 0, 1, 0, 0, 4'h0); tick();
      bubble(4'hF); tick();
      chk("grp_FlagsE", {28'd0, bus1.FlagsE}, 32'hC);
      for (int i = 0; i < 5; i++) begin
         drive(4'hE, 2'b00, 0, 0, 0, 0, 1, 0, 0, 4'h0); tick();
      end
      bubble(4'h0); tick();
      chk("sat_ExecCnt_w2", {30'd0, bus2.ExecCnt}, 32'd3);
      chk("sat_ExecCnt_w16", {16'd0, bus1.ExecCnt}, 32'd6);

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 600; i++) begin
         drive(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)));
         reset = ($urandom_range(0, 99) == 0);
         tick();
      end
      reset = 1'b0;
      bubble(4'h0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/condlogic_pipe.md
CONDLOGIC_PIPE -- requirements
Module: condlogic_pipe

Interface
REQ-001 Parameter NUM_FLAG_GROUPS, default 2: independently writable flag groups; SHALL divide 4.
REQ-002 Parameter STAT_W, default 16: width of the two statistics counters; legal range 2..32.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 CondD  in  4  decode-stage condition field.
REQ-006 FlagWD  in  NUM_FLAG_GROUPS  per-group flag-write request; bit i covers flags [4/NUM_FLAG_GROUPS*(i+1)-1 : 4/NUM_FLAG_GROUPS*i].
REQ-007 PCSD, RegWD, MemWD, NoWriteD, ValidD  in  1 each  decode-stage controls; ValidD=0 marks a bubble.
REQ-008 StallE  in  1  hold the execute-stage register.
REQ-009 FlushE  in  1  load a bubble into the execute-stage register.
REQ-010 ALUFlagsE  in  4  {N,Z,C,V} from the execute-stage ALU.
REQ-011 PCSrcE, RegWriteE, MemWriteE  out  1 each  qualified write/branch enables.
REQ-012 CondExE  out  1  condition result for the instruction in E.
REQ-013 FlagsE  out  4  committed {N,Z,C,V}, used as the ALU carry-in source.
REQ-014 ExecCnt, SquashCnt  out  STAT_W each  retired-executed and retired-squashed counts.

Function
REQ-015 D->E register (Cond, FlagW, PCS, RegW, MemW, NoWrite, Valid): FlushE=1 SHALL load Valid=0 and all controls 0, regardless of StallE; otherwise StallE=1 SHALL hold; otherwise it SHALL load the D inputs.
REQ-016 CondExE SHALL be combinational from CondE and FlagsE: EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~(C&~Z); GE N==V; LT N!=V; GT ~Z&(N==V); LE ~(~Z&(N==V)); AL 1; 1111 SHALL give 0 (never X).
REQ-017 Qualifier Q = ValidE & CondExE.
REQ-018 RegWriteE = RegWE & Q & ~NoWriteE; MemWriteE = MemWE & Q; PCSrcE = PCSE & Q; all purely combinational, zero latency.
REQ-019 Flag group i SHALL load ALUFlagsE's group-i bits at the edge iff FlagWE[i] & Q & ~StallE; otherwise it SHALL hold.
REQ-020 Stalled instruction: flags SHALL NOT update until the stall cycle ends, so re-evaluation never sees its own flags.
REQ-021 Back-to-back flag-setter then conditional instruction SHALL see the new flags one cycle later without forwarding logic.
REQ-022 Retire event = ValidE & ~StallE; on retire ExecCnt increments if CondExE=1, SquashCnt increments if CondExE=0.
REQ-023 Counters SHALL saturate at all-ones and never wrap.
REQ-024 FlushE and StallE both high: flush SHALL win for the register; the current E instruction retires only if StallE=0, so it does not retire.
REQ-025 A flag write and a condition evaluation in the same cycle SHALL use the pre-edge FlagsE.

Reset
REQ-026 reset=1 SHALL clear the E register (ValidE=0, all controls 0), FlagsE=4'b0000, ExecCnt=0, SquashCnt=0; this has priority over StallE and FlushE.
REQ-027 During and in the cycle after reset, PCSrcE, RegWriteE and MemWriteE SHALL be 0; CondExE follows CondE=0000 with Z=0, giving 0.
REQ-028 Reset mid-operation SHALL discard the in-flight instruction with no flag or counter update.

Structure
REQ-029 Shared package condlogic_pkg SHALL hold the cond_t enum (EQ..AL, NV=1111), the flag index constants N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0, and the E-stage control struct type.
REQ-030 A single sub-module cond_eval (Cond, Flags -> CondEx, combinational) SHALL implement REQ-016; everything else stays in condlogic_pipe.

Verification
REQ-031 Reset, then CMP-like FlagWD=11 with ALUFlagsE=0100, Cond=1110 -> FlagsE=0100 next cycle; following BEQ (Cond=0000, PCSD=1) -> PCSrcE=1, ExecCnt=2.
REQ-032 FlagsE=0000, RegWD=1 with Cond=0000 -> RegWriteE=0, SquashCnt+1; same with NoWriteD=1 and Cond=1110 -> RegWriteE=0, ExecCnt+1.
REQ-033 StallE=1 for 3 cycles with a flag-setter in E (ALUFlagsE=1000) -> FlagsE unchanged and counters frozen until StallE falls, then FlagsE=1000 and exactly one count.
REQ-034 FlushE=1 with StallE=1 and a valid branch in D -> next cycle ValidE=0, PCSrcE=0, no counter change; Cond=1111 -> CondExE=0.
REQ-035 NUM_FLAG_GROUPS=2, FlagWD=10, ALUFlagsE=1111 from FlagsE=0000 -> FlagsE=1100; STAT_W=2 with 5 retires -> ExecCnt=3 (saturated).
